// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and the
// index-width helper used to size grant indices and the rotating pointer.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Width needed to index n requesters, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter_chk.sv
// Grant-consistency properties for rr_arbiter outputs: one-hot while valid,
// all-zero while idle, and index always matching the one-hot vector.
module rr_arbiter_chk #(
    parameter int N_REQ     = 4,
    parameter int IDX_WIDTH = 2
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    input logic                 i_gnt_valid,
    input logic [N_REQ-1:0]     i_gnt_onehot,
    input logic [IDX_WIDTH-1:0] i_gnt_idx
);

    logic [N_REQ-1:0] w_idx_onehot;

    assign w_idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << i_gnt_idx;

    a_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_gnt_valid |-> $onehot(i_gnt_onehot));

    a_idle_zero: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !i_gnt_valid |-> ((i_gnt_onehot == '0) && (i_gnt_idx == '0)));

    a_idx_match: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_gnt_valid |-> (i_gnt_onehot == w_idx_onehot));

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection: the lowest set request at or
// above the pointer wins; if none, the lowest set request overall wins.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int IDX_WIDTH = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0]     i_req,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [N_REQ-1:0]     o_win_onehot,
    output logic [IDX_WIDTH-1:0] o_win_idx,
    output logic                 o_any
);

    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_hi_req;
    logic [N_REQ-1:0] w_src;
    logic [N_REQ-1:0] w_low;
    logic             w_hi_any;

    // Priority window: positions from ptr upward are served before wrapping.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_mask[i] = (i >= int'(i_ptr));
        end
    end

    assign w_hi_req = i_req & w_mask;
    assign w_hi_any = |w_hi_req;
    assign w_src    = w_hi_any ? w_hi_req : i_req;
    // Two's-complement trick isolates the lowest set bit of the chosen window.
    assign w_low    = w_src & (~w_src + {{(N_REQ-1){1'b0}}, 1'b1});

    // Binary encoding of the one-hot winner.
    always_comb begin
        o_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_low[i]) begin
                o_win_idx = o_win_idx | IDX_WIDTH'(i);
            end else begin
                o_win_idx = o_win_idx;
            end
        end
    end

    assign o_win_onehot = w_low;
    assign o_any        = |i_req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered valid/ready grant; the pointer moves
// only on a handshake, and a handshake re-arbitrates without a bubble.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int IDX_WIDTH = clog2_min1(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic                 gnt_ready,
    output logic                 gnt_valid,
    output logic [N_REQ-1:0]     gnt_onehot,
    output logic [IDX_WIDTH-1:0] gnt_idx
);

    arb_state_e           r_state;
    logic [IDX_WIDTH-1:0] r_ptr;
    logic [N_REQ-1:0]     r_onehot;
    logic [IDX_WIDTH-1:0] r_idx;

    arb_state_e           w_state_nxt;
    logic [IDX_WIDTH-1:0] w_ptr_nxt;
    logic [N_REQ-1:0]     w_onehot_nxt;
    logic [IDX_WIDTH-1:0] w_idx_nxt;

    logic                 w_hs;
    logic [IDX_WIDTH-1:0] w_ptr_inc;
    logic [IDX_WIDTH-1:0] w_pick_ptr;
    logic [N_REQ-1:0]     w_win_onehot;
    logic [IDX_WIDTH-1:0] w_win_idx;
    logic                 w_any;

    assign w_hs      = (r_state == ST_GRANT) & gnt_ready;
    assign w_ptr_inc = (r_idx == IDX_WIDTH'(N_REQ - 1)) ? '0 : (r_idx + IDX_WIDTH'(1));
    // On a handshake the arbitration must already see the advanced pointer.
    assign w_pick_ptr = w_hs ? w_ptr_inc : r_ptr;

    rr_pick #(
        .N_REQ     (N_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .i_req        (req),
        .i_ptr        (w_pick_ptr),
        .o_win_onehot (w_win_onehot),
        .o_win_idx    (w_win_idx),
        .o_any        (w_any)
    );

    // Next state, pointer and grant contents.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_onehot_nxt = r_onehot;
        w_idx_nxt    = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt  = ST_GRANT;
                    w_onehot_nxt = w_win_onehot;
                    w_idx_nxt    = w_win_idx;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (gnt_ready) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (w_any) begin
                        w_state_nxt  = ST_GRANT;
                        w_onehot_nxt = w_win_onehot;
                        w_idx_nxt    = w_win_idx;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_onehot_nxt = '0;
                        w_idx_nxt    = '0;
                    end
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_ptr_nxt    = '0;
                w_onehot_nxt = '0;
                w_idx_nxt    = '0;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_onehot <= '0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_onehot <= w_onehot_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    assign gnt_valid  = (r_state == ST_GRANT);
    assign gnt_onehot = r_onehot;
    assign gnt_idx    = r_idx;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed vector table, hand-written
// reset/wrap sequences, and random traffic against a priority-order model.
module tb_rr_arbiter;

    localparam int N4 = 4;
    localparam int N5 = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req4;
    logic       rdy4;
    logic       v4;
    logic [3:0] oh4;
    logic [1:0] idx4;
    logic [4:0] req5;
    logic       rdy5;
    logic       v5;
    logic [4:0] oh5;
    logic [2:0] idx5;

    int n_tests = 0;
    int n_fail  = 0;

    logic m_valid;
    int   m_idx;
    int   m_ptr;

    always #5 clk = ~clk;

    rr_arbiter #(.N_REQ(N4), .IDX_WIDTH(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .gnt_ready(rdy4),
        .gnt_valid(v4), .gnt_onehot(oh4), .gnt_idx(idx4)
    );

    rr_arbiter #(.N_REQ(N5), .IDX_WIDTH(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .gnt_ready(rdy5),
        .gnt_valid(v5), .gnt_onehot(oh5), .gnt_idx(idx5)
    );

    rr_arbiter_chk #(.N_REQ(N4), .IDX_WIDTH(2)) chk4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_gnt_valid(v4),
        .i_gnt_onehot(oh4), .i_gnt_idx(idx4)
    );

    rr_arbiter_chk #(.N_REQ(N5), .IDX_WIDTH(3)) chk5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_gnt_valid(v5),
        .i_gnt_onehot(oh5), .i_gnt_idx(idx5)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       exp_v;
        logic [3:0] exp_oh;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic ev, input logic [3:0] eoh, input logic [1:0] eidx);
        check({tag, " valid"},  32'(v4),   32'(ev));
        check({tag, " onehot"}, 32'(oh4),  32'(eoh));
        check({tag, " idx"},    32'(idx4), 32'(eidx));
    endtask

    // Reset with all requests asserted; outputs must stay clear throughout.
    task automatic do_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        req4  = 4'b1111;
        req5  = 5'b11111;
        rdy4  = 1'b1;
        rdy5  = 1'b1;
        #1;
        check4("reset immediate", 1'b0, 4'b0000, 2'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check4($sformatf("reset held c%0d", c), 1'b0, 4'b0000, 2'd0);
            check("reset held dut5 valid", 32'(v5), 32'd0);
        end
        rst_n   = 1'b1;
        req4    = 4'b0000;
        req5    = 5'b00000;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    function automatic int rr_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < N4; k++) begin
            if (r[(p + k) % N4]) return (p + k) % N4;
        end
        return 0;
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic rdy);
        if (!m_valid) begin
            if (r != 4'd0) begin
                m_idx   = rr_winner(r, m_ptr);
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            m_ptr = (m_idx + 1) % N4;
            if (r != 4'd0) begin
                m_idx = rr_winner(r, m_ptr);
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    endtask

    initial begin
        logic [3:0] r;
        logic       rd;
        logic [3:0] exp_oh;
        int         wrap_exp[4];

        req4 = 4'b0000;
        req5 = 5'b00000;
        rdy4 = 1'b0;
        rdy5 = 1'b0;
        m_valid = 1'b0;
        m_idx = 0;
        m_ptr = 0;

        // Alternation 1,3,1,3 then drop to idle.
        vecs.push_back('{1'b1, 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{1'b0, 4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3});
        vecs.push_back('{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{1'b0, 4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0});
        // Full load 0,1,2,3,0,1; handshake into idle leaves ptr=2.
        vecs.push_back('{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0});
        // Backpressure: grant 0 held while req drops, then idle; ptr becomes 1.
        vecs.push_back('{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 2'd0});
        vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2});
        // Single persistent requester is re-granted each handshake.
        vecs.push_back('{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2});
        vecs.push_back('{1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2});
        vecs.push_back('{1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2});

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset();
            end
            req4 = vecs[i].req;
            rdy4 = vecs[i].rdy;
            tick();
            check4($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_oh, vecs[i].exp_idx);
        end

        // Reset pulse between edges while granting idx 2 with ptr at 3.
        do_reset();
        req4 = 4'b0100;
        rdy4 = 1'b1;
        tick();
        tick();
        check4("midrst before", 1'b1, 4'b0100, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check4("midrst cleared", 1'b0, 4'b0000, 2'd0);
        rst_n = 1'b1;
        req4  = 4'b1111;
        tick();
        check4("midrst first grant", 1'b1, 4'b0001, 2'd0);

        // Five requesters: pointer must wrap from 4 back to 0.
        do_reset();
        req4 = 4'b0000;
        req5 = 5'b10001;
        rdy5 = 1'b1;
        wrap_exp = '{0, 4, 0, 4};
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("wrap%0d valid", k),  32'(v5),   32'd1);
            check($sformatf("wrap%0d idx", k),    32'(idx5), 32'(wrap_exp[k]));
            check($sformatf("wrap%0d onehot", k), 32'(oh5),  32'd1 << wrap_exp[k]);
        end
        req5 = 5'b00000;

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) != 0);
            req4 = r;
            rdy4 = rd;
            tick();
            model_edge(r, rd);
            exp_oh = m_valid ? (4'b0001 << m_idx) : 4'b0000;
            check4($sformatf("rand%0d", c), m_valid, exp_oh, 2'(m_idx));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters (legal range 2..32).
REQ-002 Parameter: IDX_WIDTH, default 2, grant index width; shall equal max(1, ceil(log2(N_REQ))).
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: req  input  N_REQ  request vector; bit i high means requester i wants service; any bit pattern is legal.
REQ-006 Port: gnt_ready  input  1  downstream accepts the current grant.
REQ-007 Port: gnt_valid  output  1  a grant is presented.
REQ-008 Port: gnt_onehot  output  N_REQ  one-hot grant; it feeds the index encoder stage downstream.
REQ-009 Port: gnt_idx  output  IDX_WIDTH  binary index of the granted requester; it shall always match gnt_onehot.

Function
REQ-010 The block shall have two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-011 A rotating pointer ptr (IDX_WIDTH bits) shall give the highest-priority requester; priority shall descend ptr, ptr+1, ..., wrapping modulo N_REQ.
REQ-012 In IDLE, if req is non-zero, the block shall register the winner into gnt_onehot and gnt_idx, set gnt_valid, and enter GRANT on the next edge; the latency from req to gnt_valid shall be 1 cycle.
REQ-013 In IDLE with req all zero, the outputs shall not change.
REQ-014 In GRANT, gnt_onehot and gnt_idx shall hold stable until a handshake (gnt_valid and gnt_ready high at the same edge), even if the granted req bit drops.
REQ-015 On handshake, ptr shall become (gnt_idx+1) mod N_REQ; for N_REQ not a power of two, ptr shall wrap from N_REQ-1 to 0.
REQ-016 On the handshake cycle, arbitration shall be re-evaluated over the current req using the updated ptr. If any bit is set, the block shall stay in GRANT with the new winner on the next cycle (back-to-back, no bubble). Otherwise it shall go to IDLE with gnt_onehot=0 and gnt_idx=0.
REQ-017 In GRANT with gnt_ready=0, ptr shall not change.
REQ-018 gnt_onehot shall have exactly one bit set when gnt_valid=1 and shall be all zero when gnt_valid=0.
REQ-019 A single persistent requester shall be re-granted on consecutive handshakes.

Reset
REQ-020 While rst_n=0, gnt_valid=0, gnt_onehot=0, gnt_idx=0, ptr=0 and state=IDLE, regardless of clk.
REQ-021 If reset is asserted mid-GRANT, the pending grant shall be discarded with no handshake credited.
REQ-022 After rst_n deasserts, the first grant shall be evaluated on the first rising clk edge with rst_n=1.

Structure
REQ-023 A shared package arb_pkg shall hold the IDLE/GRANT state encodings and the ceil-log2 helper used to derive IDX_WIDTH.
REQ-024 Winner selection shall sit in one combinational sub-module, rr_pick (inputs req and ptr; outputs a one-hot winner, its index, and an any-request flag).
REQ-025 rr_arbiter shall contain only the state register, ptr and the output registers.

Verification
REQ-026 The bench shall check reset: hold rst_n=0 with req=4'b1111 -> gnt_valid=0, gnt_onehot=0000, gnt_idx=0 throughout.
REQ-027 The bench shall check alternation: N_REQ=4, req=4'b1010, gnt_ready=1 from reset -> grants idx 1,3,1,3 on consecutive cycles with no bubble.
REQ-028 The bench shall check backpressure: req=4'b0001, gnt_ready=0 for 3 cycles, req dropped in cycle 2 -> gnt_onehot=0001 and gnt_idx=0 held; then gnt_ready=1 -> IDLE next cycle.
REQ-029 The bench shall check full load: req=4'b1111, gnt_ready=1 -> idx sequence 0,1,2,3,0,1.
REQ-030 The bench shall check wrap: N_REQ=5, req=5'b10001 -> idx sequence 0,4,0,4, confirming ptr wraps 4->0.
REQ-031 The bench shall check reset mid-operation: while gnt_valid=1 with gnt_idx=2, pulse rst_n low between clock edges -> outputs clear immediately; the first grant after release comes from ptr=0.
